reg_file_mp: RTL and testbench

Parametrised multi-read-port register file for the MIPS datapath, the next generation of the lab register file. Adds configurable data width, depth and read-port count, an optional write-to-read bypass, and a synchronous reset sequencer that clears every register before the file accepts traffic. It sits between decode (read addresses) and write-back (write port), feeding operands to the execute stage one cycle after address presentation.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_clr_fsm.sv | 48 ++++
 rtl/reg_file_mp.sv | 88 ++++++++
 tb/tb_reg_file_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default parameter values for the multi-port register file.
package reg_file_pkg;

  // Clear sequencer states: sweep storage to zero, then serve traffic.
  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefAddrW   = 5;
  localparam int unsigned DefRdPorts = 2;
  localparam bit          DefZeroReg = 1'b1;
  localparam bit          DefBypass  = 1'b1;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Reset sequencer: walks a pointer over every entry after reset, producing a
// zeroing write per cycle, then raises ready and stays in service.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  output state_e            state,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ready_q;

  // State, clear pointer and registered ready; last entry hands over to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (&ptr_q) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign ready    = ready_q;
  // No storage write on a reset edge, even mid-sweep.
  assign clr_we   = (state_q == StClear) && !rst;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file with RD_PORTS registered read ports, optional
// hard-wired zero register, optional write-to-read forwarding, and a clear
// sequence that zeroes all storage before o_ready rises.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned RD_PORTS = DefRdPorts,
  parameter bit          ZERO_REG = DefZeroReg,
  parameter bit          BYPASS   = DefBypass
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [RD_PORTS*ADDR_W-1:0]   i_raddr,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic                         i_we,
  output logic [RD_PORTS*DATA_W-1:0]   o_rdata,
  output logic                         o_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              usr_we;
  logic              waddr_zero;

  logic [DATA_W-1:0] mem_q [DEPTH];

  reg_file_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (i_clk),
    .rst      (i_rst),
    .state    (state),
    .ready    (o_ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign waddr_zero = ZERO_REG && (i_waddr == '0);
  assign usr_we     = (state == StRun) && !i_rst && i_we && !waddr_zero;

  // Storage: clear sweep has priority; user writes only accepted in RUN.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (usr_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    assign raddr = i_raddr[k*ADDR_W +: ADDR_W];

    // Read mux: storage, then same-cycle forwarding, then the zero register.
    always_comb begin
      rd_d = mem_q[raddr];
      if (BYPASS && i_we && (i_waddr == raddr)) begin
        rd_d = i_wdata;
      end
      if (ZERO_REG && (raddr == '0)) begin
        rd_d = '0;
      end
    end

    // Output register: held at zero until the file is in service.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rd_q <= '0;
      end else if (state != StRun) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign o_rdata[k*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two 32x32 instances (forwarding on / off) share one
// stimulus stream; a 8x16 three-port instance runs alongside. A per-instance
// behavioural model is checked after every edge, plus directed tables.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus for instances A (forwarding) and B (no forwarding).
  logic        rst, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra [2];
  logic [9:0]  raddr_ab;
  logic [63:0] rdata_a, rdata_b;
  logic        ready_a, ready_b;
  assign raddr_ab = {ra[1], ra[0]};

  // Stimulus for instance C (8 entries, 16 bits, 3 ports).
  logic        rst_c, we_c;
  logic [2:0]  waddr_c;
  logic [15:0] wdata_c;
  logic [2:0]  ra_c [3];
  logic [8:0]  raddr_c;
  logic [47:0] rdata_c;
  logic        ready_c;
  assign raddr_c = {ra_c[2], ra_c[1], ra_c[0]};

  reg_file_mp #(
    .DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr_ab), .i_waddr(waddr), .i_wdata(wdata),
    .i_we(we), .o_rdata(rdata_a), .o_ready(ready_a)
  );

  reg_file_mp #(
    .DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr_ab), .i_waddr(waddr), .i_wdata(wdata),
    .i_we(we), .o_rdata(rdata_b), .o_ready(ready_b)
  );

  reg_file_mp #(
    .DATA_W(16), .ADDR_W(3), .RD_PORTS(3), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_raddr(raddr_c), .i_waddr(waddr_c), .i_wdata(wdata_c),
    .i_we(we_c), .o_rdata(rdata_c), .o_ready(ready_c)
  );

  // Reference model: after reset, `depth` quiet edges elapse before the file
  // is usable with every entry zero; reads see pre-write contents unless forwarded.
  int unsigned cfg_depth  [3] = '{32, 32, 8};
  int unsigned cfg_ports  [3] = '{2, 2, 3};
  bit          cfg_bypass [3] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] m_mem   [3][32];
  bit          m_ready [3];
  int          m_left  [3];
  logic [31:0] m_rd    [3][3];

  task automatic model_edge(input int i, input bit r, input bit w, input int wa,
                            input logic [31:0] wd, input int a0, input int a1, input int a2);
    int a [3];
    logic [31:0] v;
    a[0] = a0; a[1] = a1; a[2] = a2;
    if (r) begin
      m_ready[i] = 1'b0;
      m_left[i]  = int'(cfg_depth[i]);
      for (int k = 0; k < 3; k++) m_rd[i][k] = '0;
    end else if (!m_ready[i]) begin
      for (int k = 0; k < 3; k++) m_rd[i][k] = '0;
      m_left[i] = m_left[i] - 1;
      if (m_left[i] == 0) begin
        m_ready[i] = 1'b1;
        for (int j = 0; j < 32; j++) m_mem[i][j] = '0;
      end
    end else begin
      for (int k = 0; k < int'(cfg_ports[i]); k++) begin
        v = m_mem[i][a[k]];
        if (cfg_bypass[i] && w && (wa == a[k])) v = wd;
        if (a[k] == 0) v = '0;
        m_rd[i][k] = v;
      end
      if (w && (wa != 0)) m_mem[i][wa] = wd;
    end
  endtask

  function automatic logic [31:0] act_rd(input int i, input int k);
    case (i)
      0:       return rdata_a[k*32 +: 32];
      1:       return rdata_b[k*32 +: 32];
      default: return {16'h0, rdata_c[k*16 +: 16]};
    endcase
  endfunction

  function automatic logic act_ready(input int i);
    case (i)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock edge: advance the model with the pre-edge inputs, compare all outputs.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge(0, rst, we, int'(waddr), wdata, int'(ra[0]), int'(ra[1]), 0);
    model_edge(1, rst, we, int'(waddr), wdata, int'(ra[0]), int'(ra[1]), 0);
    model_edge(2, rst_c, we_c, int'(waddr_c), {16'h0, wdata_c},
               int'(ra_c[0]), int'(ra_c[1]), int'(ra_c[2]));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model ready inst%0d", i), {31'h0, act_ready(i)}, {31'h0, m_ready[i]});
      for (int k = 0; k < int'(cfg_ports[i]); k++)
        check($sformatf("model rdata inst%0d port%0d", i, k), act_rd(i, k), m_rd[i][k]);
    end
  endtask

  task automatic read_all_zero_ab(input string tag);
    we = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      ra[0] = 5'(a);
      ra[1] = 5'(a + 1);
      step();
      check($sformatf("%s a r%0d", tag, a), rdata_a[31:0], 32'h0);
      check($sformatf("%s a r%0d", tag, a + 1), rdata_a[63:32], 32'h0);
      check($sformatf("%s b r%0d", tag, a), rdata_b[31:0], 32'h0);
    end
  endtask

  typedef struct {
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0, ra1;
    logic [31:0] ea0, ea1, eb0, eb1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF,
                32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5,
                32'h00000001, 32'h00000001};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF,
                32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[8] = '{1'b1, 5'd5, 32'h0, 5'd5, 5'd7, 32'h0, 32'hA5A5A5A5,
                32'hDEADBEEF, 32'hA5A5A5A5};

    for (int i = 0; i < 3; i++) begin
      m_ready[i] = 1'b0;
      m_left[i]  = 0;
    end
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra[0] = '0; ra[1] = '0;
    rst_c = 1'b1; we_c = 1'b0; waddr_c = '0; wdata_c = '0;
    ra_c[0] = '0; ra_c[1] = '0; ra_c[2] = '0;

    // Reset edge.
    step();
    check("reset ready_a", {31'h0, ready_a}, 32'h0);
    check("reset rdata_a", rdata_a[31:0], 32'h0);
    check("reset ready_c", {31'h0, ready_c}, 32'h0);

    // Clear: ready rises exactly after the 32nd (A/B) / 8th (C) edge; writes ignored.
    rst = 1'b0; rst_c = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      we = 1'b1; waddr = 5'($urandom_range(0, 31)); wdata = $urandom;
      we_c = (n < 8); waddr_c = 3'($urandom_range(0, 7)); wdata_c = 16'($urandom);
      step();
      check($sformatf("clear ready_a edge%0d", n), {31'h0, ready_a}, {31'h0, (n == 32)});
      check($sformatf("clear ready_b edge%0d", n), {31'h0, ready_b}, {31'h0, (n == 32)});
      if (n <= 8)
        check($sformatf("clear ready_c edge%0d", n), {31'h0, ready_c}, {31'h0, (n == 8)});
    end
    we_c = 1'b0;
    read_all_zero_ab("post-clear");

    // Directed table on A/B.
    for (int v = 0; v < 9; v++) begin
      we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
      ra[0] = vecs[v].ra0; ra[1] = vecs[v].ra1;
      step();
      check($sformatf("vec%0d a port0", v), rdata_a[31:0], vecs[v].ea0);
      check($sformatf("vec%0d a port1", v), rdata_a[63:32], vecs[v].ea1);
      check($sformatf("vec%0d b port0", v), rdata_b[31:0], vecs[v].eb0);
      check($sformatf("vec%0d b port1", v), rdata_b[63:32], vecs[v].eb1);
    end
    we = 1'b0;

    // Small instance: three writes, then three distinct reads in one cycle.
    we_c = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      waddr_c = 3'(j); wdata_c = 16'(j * 'h11);
      step();
    end
    we_c = 1'b0;
    ra_c[0] = 3'd1; ra_c[1] = 3'd2; ra_c[2] = 3'd3;
    step();
    check("small port0 r1", {16'h0, rdata_c[15:0]}, 32'h0011);
    check("small port1 r2", {16'h0, rdata_c[31:16]}, 32'h0022);
    check("small port2 r3", {16'h0, rdata_c[47:32]}, 32'h0033);

    // Fill A/B, reset, abort the clear at pointer 10, reset again.
    we = 1'b1;
    for (int a = 1; a < 32; a++) begin
      waddr = 5'(a); wdata = 32'(a);
      step();
    end
    rst = 1'b1; step();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      waddr = 5'($urandom_range(0, 31)); wdata = $urandom;
      step();
    end
    rst = 1'b1; step();
    rst = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      waddr = 5'($urandom_range(0, 31)); wdata = $urandom;
      step();
      check($sformatf("restart ready_a edge%0d", n), {31'h0, ready_a}, {31'h0, (n == 32)});
    end
    read_all_zero_ab("post-restart");

    // Random traffic, narrow address range for frequent collisions, rare resets.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 149) == 0);
      we    = 1'($urandom);
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      ra[0] = 5'($urandom_range(0, 7));
      ra[1] = 5'($urandom_range(0, 31));
      rst_c   = ($urandom_range(0, 149) == 0);
      we_c    = 1'($urandom);
      waddr_c = 3'($urandom);
      wdata_c = 16'($urandom);
      for (int k = 0; k < 3; k++) ra_c[k] = 3'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
